// File: rtl/jtag_rpc_pkg.sv
// Shared encodings for the JTAG RPC bridge: RPC_ADD command field and bus FSM states.
package jtag_rpc_pkg;

    typedef enum logic [1:0] {
        CMD_ADDR   = 2'b00,
        CMD_READ   = 2'b01,
        CMD_WRARM  = 2'b10,
        CMD_CLRERR = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/jtag_dr_shift.sv
// Capture/shift data register for one JTAG instruction; LSB is shifted out first.
module jtag_dr_shift
    import jtag_rpc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             jtag_clk,
    input  logic             trst_n_pad_in,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             select_i,
    input  logic             tdi_i,
    input  logic [WIDTH-1:0] capture_val_i,
    output logic [WIDTH-1:0] value_o,
    output logic             tdo_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (select_i) begin
            if (capture_i) begin
                sr_d = capture_val_i;
            end else if (shift_i) begin
                sr_d = {tdi_i, sr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge jtag_clk or negedge trst_n_pad_in) begin
        if (!trst_n_pad_in) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign value_o = sr_q;
    assign tdo_o   = sr_q[0];

endmodule

// File: rtl/jtag_rpc_bridge.sv
// Turns RPC_ADD / RPC_DATA update events into single req/ack bus transactions.
//   state   | meaning
//   ST_IDLE | no transaction outstanding; updates may start one
//   ST_REQ  | bus_req high, waiting for bus_ack or timeout
module jtag_rpc_bridge
    import jtag_rpc_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int AUTO_INC   = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                  jtag_clk,
    input  logic                  trst_n_pad_in,
    input  logic                  test_logic_reset_i,
    input  logic                  capture_dr_i,
    input  logic                  shift_dr_i,
    input  logic                  update_dr_i,
    input  logic                  tdi_i,
    input  logic                  select_i,
    input  logic                  aux_select_i,
    output logic                  tdo_o,
    output logic                  aux_tdo_o,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    input  logic                  bus_err
);

    localparam int ADD_W = ADDR_WIDTH + 2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  wmode_q, wmode_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADD_W-1:0]      add_val;
    logic [DATA_WIDTH-1:0] data_val;
    logic                  busy, start, start_we;
    cmd_e                  cmd;

    assign busy = (state_q == ST_REQ);
    assign cmd  = cmd_e'(add_val[ADD_W-1 -: 2]);

    jtag_dr_shift #(.WIDTH(ADD_W)) u_rpc_add (
        .jtag_clk      (jtag_clk),
        .trst_n_pad_in (trst_n_pad_in),
        .capture_i     (capture_dr_i),
        .shift_i       (shift_dr_i),
        .select_i      (select_i),
        .tdi_i         (tdi_i),
        .capture_val_i ({busy, err_q, addr_q}),
        .value_o       (add_val),
        .tdo_o         (tdo_o)
    );

    jtag_dr_shift #(.WIDTH(DATA_WIDTH)) u_rpc_data (
        .jtag_clk      (jtag_clk),
        .trst_n_pad_in (trst_n_pad_in),
        .capture_i     (capture_dr_i),
        .shift_i       (shift_dr_i),
        .select_i      (aux_select_i),
        .tdi_i         (tdi_i),
        .capture_val_i (rdata_q),
        .value_o       (data_val),
        .tdo_o         (aux_tdo_o)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wmode_d  = wmode_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        start    = 1'b0;
        start_we = 1'b0;

        // Address and write data are frozen while a request is outstanding.
        if (update_dr_i && select_i) begin
            unique case (cmd)
                CMD_ADDR: if (!busy) begin
                    addr_d  = add_val[ADDR_WIDTH-1:0];
                    wmode_d = 1'b0;
                end
                CMD_READ: if (busy) begin
                    err_d = 1'b1;
                end else begin
                    addr_d  = add_val[ADDR_WIDTH-1:0];
                    wmode_d = 1'b0;
                    start   = 1'b1;
                end
                CMD_WRARM: if (!busy) begin
                    addr_d  = add_val[ADDR_WIDTH-1:0];
                    wmode_d = 1'b1;
                end
                CMD_CLRERR: err_d = 1'b0;
                default: ;
            endcase
        end else if (update_dr_i && aux_select_i) begin
            if (busy) begin
                err_d = 1'b1;
            end else begin
                start    = 1'b1;
                start_we = wmode_q;
                if (wmode_q) begin
                    wdata_d = data_val;
                end
            end
        end

        unique case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_REQ;
                cnt_d   = '0;
                we_d    = start_we;
            end
            ST_REQ: begin
                if (bus_ack || cnt_q == CNT_TC) begin
                    state_d = ST_IDLE;
                    if (AUTO_INC != 0) begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    if (bus_err) begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q == CNT_TC) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (test_logic_reset_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
            wmode_d = 1'b0;
            we_d    = we_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
            rdata_d = rdata_q;
        end
    end

    always_ff @(posedge jtag_clk or negedge trst_n_pad_in) begin
        if (!trst_n_pad_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wmode_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wmode_q <= wmode_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_req   = busy;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_jtag_rpc_bridge.sv
// Self-checking bench for jtag_rpc_bridge: directed scenarios plus a randomized op sequence.
module tb_jtag_rpc_bridge;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int T  = 255;

    logic          jtag_clk, trst_n_pad_in, test_logic_reset_i;
    logic          capture_dr_i, shift_dr_i, update_dr_i, tdi_i;
    logic          select_i, aux_select_i, tdo_o, aux_tdo_o;
    logic          bus_req, bus_we, bus_ack, bus_err;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;

    jtag_rpc_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUTO_INC(1), .TIMEOUT(T)) dut (
        .jtag_clk(jtag_clk), .trst_n_pad_in(trst_n_pad_in),
        .test_logic_reset_i(test_logic_reset_i),
        .capture_dr_i(capture_dr_i), .shift_dr_i(shift_dr_i), .update_dr_i(update_dr_i),
        .tdi_i(tdi_i), .select_i(select_i), .aux_select_i(aux_select_i),
        .tdo_o(tdo_o), .aux_tdo_o(aux_tdo_o),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    initial jtag_clk = 1'b0;
    always #5 jtag_clk = ~jtag_clk;

    int vec = 0;
    int miscmp = 0;

    // Slave: acks s_lat cycles after bus_req rises (s_lat < 1 means never).
    int            s_lat = -1;
    logic [DW-1:0] s_data = '0;
    logic          s_err = 1'b0;
    int            req_cnt = 0, req_len = 0, stab_bad = 0, cyc = 0;
    bit            in_req = 0;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;

    initial begin
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        forever begin
            @(posedge jtag_clk); #1;
            if (bus_req) begin
                if (!in_req) begin
                    in_req = 1; req_cnt++; cyc = 0;
                    r_addr = bus_addr; r_we = bus_we; r_wdata = bus_wdata;
                end else if (bus_addr !== r_addr || bus_we !== r_we || bus_wdata !== r_wdata) begin
                    stab_bad++;
                end
                cyc++; req_len = cyc;
                if (s_lat > 0 && cyc == s_lat) begin
                    bus_ack = 1'b1; bus_err = s_err; bus_rdata = s_data;
                end else begin
                    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
                end
            end else begin
                in_req = 0; bus_ack = 1'b0; bus_err = 1'b0;
            end
        end
    end

    // Reference model of the bridge's architectural state.
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata, m_wdata;
    logic          m_err, m_wmode;
    int            m_reqs;

    task automatic model_reset();
        m_addr = '0; m_rdata = '0; m_wdata = '0; m_err = 0; m_wmode = 0;
    endtask

    task automatic model_done(input bit we);
        bit to;
        to = (s_lat < 1) || (s_lat > T);
        if (!to && !we) m_rdata = s_data;
        if (to || s_err) m_err = 1'b1;
        m_addr = m_addr + 1'b1;
        m_reqs++;
    endtask

    task automatic tick();
        @(posedge jtag_clk); #2;
    endtask

    task automatic scan_add(input logic [AW+1:0] din, input bit upd, output logic [AW+1:0] dout);
        select_i = 1; capture_dr_i = 1; tick(); capture_dr_i = 0; shift_dr_i = 1;
        for (int i = 0; i < AW + 2; i++) begin
            tdi_i = din[i]; dout[i] = tdo_o; tick();
        end
        shift_dr_i = 0;
        if (upd) begin update_dr_i = 1; tick(); update_dr_i = 0; end
        select_i = 0;
    endtask

    task automatic scan_data(input logic [DW-1:0] din, input bit upd, output logic [DW-1:0] dout);
        aux_select_i = 1; capture_dr_i = 1; tick(); capture_dr_i = 0; shift_dr_i = 1;
        for (int i = 0; i < DW; i++) begin
            tdi_i = din[i]; dout[i] = aux_tdo_o; tick();
        end
        shift_dr_i = 0;
        if (upd) begin update_dr_i = 1; tick(); update_dr_i = 0; end
        aux_select_i = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus_req && n < 400) begin tick(); n++; end
        vec++;
        if (bus_req) begin
            miscmp++; $display("FAIL wait_idle: bus_req still %b after %0d cycles, required 0", bus_req, n);
        end
        tick(); tick();
    endtask

    task automatic test_reset();
        logic [AW+1:0] st;
        logic [DW-1:0] dt;
        tick(); tick();
        vec++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, tdo_o, aux_tdo_o} !== '0) begin
            miscmp++; $display("FAIL reset_held: got %h required 0", {bus_req, bus_we, bus_addr, bus_wdata, tdo_o, aux_tdo_o});
        end
        trst_n_pad_in = 1; tick();
        s_lat = -1;
        scan_add({2'b01, 16'h1234}, 1, st);
        tick(); tick();
        vec++;
        if (bus_req !== 1'b1) begin
            miscmp++; $display("FAIL reset_pre_req: bus_req %b required 1", bus_req);
        end
        #3 trst_n_pad_in = 0;
        #1;
        vec++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, tdo_o, aux_tdo_o} !== '0) begin
            miscmp++; $display("FAIL reset_async: got %h required 0", {bus_req, bus_we, bus_addr, bus_wdata, tdo_o, aux_tdo_o});
        end
        tick(); tick(); trst_n_pad_in = 1; tick();
        model_reset(); m_reqs = 1;
        scan_add('0, 0, st);
        vec++;
        if (st !== '0) begin
            miscmp++; $display("FAIL reset_add_capture: got %h required 0", st);
        end
        scan_data('0, 0, dt);
        vec++;
        if (dt !== '0) begin
            miscmp++; $display("FAIL reset_data_capture: got %h required 0", dt);
        end
    endtask

    task automatic test_read();
        logic [AW+1:0] st;
        logic [DW-1:0] dt;
        s_lat = 3; s_data = 32'hDEADBEEF; s_err = 0;
        scan_add({2'b01, 16'h0010}, 1, st);
        m_addr = 16'h0010; m_wmode = 0;
        wait_idle(); model_done(0);
        vec++;
        if (req_len !== 3) begin
            miscmp++; $display("FAIL read_req_len: got %0d required 3", req_len);
        end
        scan_data('0, 0, dt);
        vec++;
        if (dt !== 32'hDEADBEEF) begin
            miscmp++; $display("FAIL read_rdata: got %h required deadbeef", dt);
        end
        vec++;
        if (bus_addr !== 16'h0011 || bus_addr !== m_addr) begin
            miscmp++; $display("FAIL read_autoinc: got %h required 0011", bus_addr);
        end
    endtask

    task automatic test_write();
        logic [AW+1:0] st;
        logic [DW-1:0] dt, d2;
        s_lat = 2; s_err = 0;
        scan_add({2'b10, 16'h0100}, 1, st);
        m_addr = 16'h0100; m_wmode = 1;
        scan_data(32'hCAFEF00D, 1, dt);
        m_wdata = 32'hCAFEF00D;
        wait_idle(); model_done(1);
        vec++;
        if ({r_we, r_addr, r_wdata} !== {1'b1, 16'h0100, 32'hCAFEF00D}) begin
            miscmp++; $display("FAIL write1: got we=%b addr=%h wdata=%h required 1/0100/cafef00d", r_we, r_addr, r_wdata);
        end
        d2 = $urandom;
        scan_data(d2, 1, dt);
        m_wdata = d2;
        wait_idle(); model_done(1);
        vec++;
        if ({r_we, r_addr, r_wdata} !== {1'b1, 16'h0101, d2}) begin
            miscmp++; $display("FAIL write2: got we=%b addr=%h wdata=%h required 1/0101/%h", r_we, r_addr, r_wdata, d2);
        end
    endtask

    task automatic test_timeout();
        logic [AW+1:0] st;
        logic [AW-1:0] a;
        a = 16'(($urandom));
        s_lat = -1; s_err = 0;
        scan_add({2'b01, a}, 1, st);
        m_addr = a; m_wmode = 0;
        wait_idle(); model_done(0);
        vec++;
        if (req_len !== T) begin
            miscmp++; $display("FAIL timeout_len: got %0d required %0d", req_len, T);
        end
        scan_add('0, 0, st);
        vec++;
        if (st !== {1'b0, 1'b1, m_addr}) begin
            miscmp++; $display("FAIL timeout_status: got %h required %h", st, {1'b0, 1'b1, m_addr});
        end
        scan_add({2'b11, 16'h0}, 1, st);
        m_err = 0;
        scan_add('0, 0, st);
        vec++;
        if (st !== {1'b0, 1'b0, m_addr}) begin
            miscmp++; $display("FAIL clrerr_status: got %h required %h", st, {1'b0, 1'b0, m_addr});
        end
    endtask

    task automatic test_overrun();
        logic [AW+1:0] st;
        logic [DW-1:0] dt;
        int base;
        base = req_cnt;
        s_lat = 60; s_data = $urandom; s_err = 0;
        scan_data('0, 1, dt);
        scan_data('0, 1, dt);
        wait_idle(); model_done(0); m_err = 1;
        vec++;
        if (req_cnt - base !== 1) begin
            miscmp++; $display("FAIL overrun_count: got %0d required 1", req_cnt - base);
        end
        scan_add('0, 0, st);
        vec++;
        if (st !== {1'b0, m_err, m_addr}) begin
            miscmp++; $display("FAIL overrun_status: got %h required %h", st, {1'b0, m_err, m_addr});
        end
        scan_add({2'b11, 16'h0}, 1, st);
        m_err = 0;
    endtask

    task automatic test_ack_edge();
        logic [AW+1:0] st;
        logic [DW-1:0] dt;
        int base;
        for (int k = 0; k < 3; k++) begin
            base = req_cnt;
            s_lat = (k == 0) ? 2 : T;
            s_err = (k != 2);
            s_data = $urandom;
            scan_data('0, 1, dt);
            wait_idle(); model_done(0);
            scan_data('0, 0, dt);
            scan_add('0, 0, st);
            vec++;
            if (dt !== m_rdata || st !== {1'b0, m_err, m_addr} || req_cnt - base !== 1) begin
                miscmp++;
                $display("FAIL ack_edge%0d: rdata=%h st=%h reqs=%0d required %h/%h/1", k, dt, st, req_cnt - base, m_rdata, {1'b0, m_err, m_addr});
            end
            scan_add({2'b11, 16'h0}, 1, st);
            m_err = 0;
        end
    endtask

    task automatic test_tlr();
        logic [AW+1:0] st;
        logic [DW-1:0] dt, d;
        logic [AW-1:0] a;
        a = 16'($urandom); d = $urandom;
        s_lat = -1; s_err = 0;
        scan_add({2'b10, a}, 1, st);
        scan_data(d, 1, dt);
        m_addr = a; m_wdata = d; m_reqs++;
        tick(); tick(); tick();
        test_logic_reset_i = 1; tick(); test_logic_reset_i = 0;
        m_err = 0; m_wmode = 0;
        vec++;
        if (bus_req !== 1'b0 || bus_addr !== m_addr || bus_wdata !== m_wdata) begin
            miscmp++; $display("FAIL tlr_abort: req=%b addr=%h wdata=%h required 0/%h/%h", bus_req, bus_addr, bus_wdata, m_addr, m_wdata);
        end
        s_lat = 2; s_data = $urandom;
        scan_data($urandom, 1, dt);
        wait_idle(); model_done(0);
        vec++;
        if (r_we !== 1'b0 || bus_wdata !== m_wdata) begin
            miscmp++; $display("FAIL tlr_wmode: we=%b wdata=%h required 0/%h", r_we, bus_wdata, m_wdata);
        end
    endtask

    task automatic test_random();
        logic [AW+1:0] st;
        logic [DW-1:0] dt, d;
        logic [AW-1:0] a, exp_addr;
        bit            chk_wr;
        int            op;
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 4);
            a = 16'($urandom); d = $urandom;
            s_lat = $urandom_range(1, 8); s_data = $urandom; s_err = ($urandom_range(0, 4) == 0);
            chk_wr = 0;
            case (op)
                0: begin scan_add({2'b00, a}, 1, st); m_addr = a; m_wmode = 0; end
                1: begin
                    scan_add({2'b01, a}, 1, st); m_addr = a; m_wmode = 0;
                    wait_idle(); model_done(0);
                end
                2: begin
                    scan_add({2'b10, a}, 1, st); m_addr = a; m_wmode = 1;
                    exp_addr = m_addr; chk_wr = 1;
                    scan_data(d, 1, dt); m_wdata = d;
                    wait_idle(); model_done(1);
                end
                3: begin
                    exp_addr = m_addr; chk_wr = m_wmode;
                    scan_data(d, 1, dt);
                    if (m_wmode) m_wdata = d;
                    wait_idle(); model_done(m_wmode);
                end
                default: begin scan_add({2'b11, a}, 1, st); m_err = 0; end
            endcase
            tick();
            scan_add('0, 0, st);
            scan_data('0, 0, dt);
            vec++;
            if (st !== {1'b0, m_err, m_addr} || dt !== m_rdata || bus_wdata !== m_wdata || req_cnt !== m_reqs) begin
                miscmp++;
                $display("FAIL rand%0d op%0d: st=%h rdata=%h wdata=%h reqs=%0d required %h/%h/%h/%0d",
                         it, op, st, dt, bus_wdata, req_cnt, {1'b0, m_err, m_addr}, m_rdata, m_wdata, m_reqs);
            end
            if (chk_wr) begin
                vec++;
                if ({r_we, r_addr, r_wdata} !== {1'b1, exp_addr, m_wdata}) begin
                    miscmp++; $display("FAIL rand%0d write: got %b/%h/%h required 1/%h/%h", it, r_we, r_addr, r_wdata, exp_addr, m_wdata);
                end
            end
        end
        vec++;
        if (stab_bad !== 0) begin
            miscmp++; $display("FAIL bus_stability: %0d changes while bus_req high, required 0", stab_bad);
        end
    endtask

    initial begin
        trst_n_pad_in = 0; test_logic_reset_i = 0;
        capture_dr_i = 0; shift_dr_i = 0; update_dr_i = 0; tdi_i = 0;
        select_i = 0; aux_select_i = 0;
        m_reqs = 0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_overrun();
        test_ack_edge();
        test_tlr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
